ss_regbank: RTL and testbench



---
 rtl/ss_regbank.sv | 173 +++++++++++++++++
 tb/tb_ss_regbank.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ss_regbank.sv
// ss_regbank: savestate register bank of COUNT words of WIDTH bits at bus
// indices BASE_INDEX..BASE_INDEX+COUNT-1. Bus reads return captured live
// state. A pulse on ss_rst walks the defaults in one register per cycle.
// Optional feature macro: SS_REGBANK_SHADOW_EN. When it is defined, bus writes
// land in shadow registers that reach state_out only on apply or at walk end.
// When it is undefined, bus writes and walk steps drive state_out directly.
module ss_regbank #(
  parameter logic [9:0]             BASE_INDEX = 10'd32,
  parameter int unsigned            COUNT      = 4,
  parameter int unsigned            WIDTH      = 64,
  parameter logic [COUNT*WIDTH-1:0] DEFAULTS   = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [63:0]            ss_din,
  input  logic [9:0]             ss_adr,
  input  logic                   ss_wren,
  input  logic                   ss_rst,
  output logic [63:0]            ss_dout,
  output logic                   ss_busy,
  input  logic                   capture,
  input  logic [COUNT*WIDTH-1:0] state_in,
  input  logic                   apply,
  output logic [COUNT*WIDTH-1:0] state_out,
  output logic                   load_valid
);

  localparam int unsigned IdxW = (COUNT > 1) ? $clog2(COUNT) : 1;

  typedef enum logic {StIdle, StWalk} state_e;

  state_e           state_q;
  logic [IdxW-1:0]  idx_q;
  logic [WIDTH-1:0] def_word [COUNT];
  logic [WIDTH-1:0] cap_q    [COUNT];
  logic [WIDTH-1:0] out_q    [COUNT];
  logic [9:0]       off;
  logic [IdxW-1:0]  off_idx;
  logic             hit;
  logic             walking;
  logic             walk_exit;
  logic             wr_ok;
  logic             unused;

  // Unsigned compare: indices below BASE_INDEX never alias via wrap-around.
  assign off       = ss_adr - BASE_INDEX;
  assign hit       = (ss_adr >= BASE_INDEX) && (off < 10'(COUNT));
  assign off_idx   = off[IdxW-1:0];
  assign walking   = (state_q == StWalk);
  assign walk_exit = walking && !ss_rst && (idx_q == IdxW'(COUNT - 1));
  assign wr_ok     = ss_wren && hit && !walking;
  assign ss_busy   = walking;

  for (genvar g = 0; g < COUNT; g++) begin : g_slices
    assign def_word[g]                  = DEFAULTS[g*WIDTH +: WIDTH];
    assign state_out[g*WIDTH +: WIDTH] = out_q[g];
  end

  // Default-reload walk: one register per cycle; ss_rst while walking restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ss_rst) begin
            state_q <= StWalk;
            idx_q   <= '0;
          end
        end
        StWalk: begin
          if (ss_rst) begin
            idx_q <= '0;
          end else if (walk_exit) begin
            state_q <= StIdle;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Capture all live state words at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < COUNT; i++) cap_q[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < COUNT; i++) cap_q[i] <= state_in[i*WIDTH +: WIDTH];
    end
  end

  // Registered bus read; uses pre-capture value and drives zero when not addressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      ss_dout <= '0;
    end else if (!ss_wren && hit) begin
      ss_dout <= 64'(cap_q[off_idx]);
    end else begin
      ss_dout <= '0;
    end
  end

`ifdef SS_REGBANK_SHADOW_EN
  logic [WIDTH-1:0] shadow_q [COUNT];
  logic [WIDTH-1:0] shadow_d [COUNT];
  logic             apply_pending_q;

  // Next shadow contents: bus write when idle, default entry when walking.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_ok) shadow_d[off_idx] = ss_din[WIDTH-1:0];
    if (walking) shadow_d[idx_q] = def_word[idx_q];
  end

  // Shadow storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < COUNT; i++) shadow_q[i] <= def_word[i];
    end else begin
      shadow_q <= shadow_d;
    end
  end

  // Transfer shadow to state_out on apply or at walk end (walk end includes the
  // final default, so it reads shadow_d); a deferred apply is absorbed there.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < COUNT; i++) out_q[i] <= def_word[i];
      load_valid      <= 1'b0;
      apply_pending_q <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      if (walk_exit) begin
        out_q           <= shadow_d;
        load_valid      <= 1'b1;
        apply_pending_q <= 1'b0;
      end else if (apply && !walking) begin
        out_q      <= shadow_q;
        load_valid <= 1'b1;
      end else if (apply && walking) begin
        apply_pending_q <= 1'b1;
      end
    end
  end

  assign unused = ^{ss_din, apply_pending_q};
`else
  // Direct mode: bus writes and walk steps update state_out immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < COUNT; i++) out_q[i] <= def_word[i];
      load_valid <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      if (wr_ok) begin
        out_q[off_idx] <= ss_din[WIDTH-1:0];
        load_valid     <= 1'b1;
      end
      if (walking) begin
        out_q[idx_q] <= def_word[idx_q];
        load_valid   <= 1'b1;
      end
    end
  end

  assign unused = ^{ss_din, apply};
`endif

endmodule

// File: tb/tb_ss_regbank.sv
// Bench for ss_regbank: random and directed stimulus, scoreboard of per-cycle
// expectations produced by a transaction-level model of the register bank.
module tb_ss_regbank;

  localparam int unsigned N = 4;
  localparam int unsigned W = 64;
  localparam logic [N*W-1:0] DEF = {64'h4444, 64'h3333, 64'h2222, 64'h1111};
  localparam logic [23:0]    DEFB = {12'h222, 12'h111};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: COUNT=4, WIDTH=64
  logic           rst_a = 1'b1;
  logic [63:0]    a_din = '0;
  logic [9:0]     a_adr = '0;
  logic           a_wren = 1'b0, a_ssrst = 1'b0, a_cap = 1'b0, a_apply = 1'b0;
  logic [N*W-1:0] a_sin = '0;
  logic [63:0]    a_dout;
  logic           a_busy, a_lv;
  logic [N*W-1:0] a_so;

  ss_regbank #(.BASE_INDEX(10'd32), .COUNT(N), .WIDTH(W), .DEFAULTS(DEF)) dut_a (
    .clk(clk), .reset(rst_a), .ss_din(a_din), .ss_adr(a_adr), .ss_wren(a_wren),
    .ss_rst(a_ssrst), .ss_dout(a_dout), .ss_busy(a_busy), .capture(a_cap),
    .state_in(a_sin), .apply(a_apply), .state_out(a_so), .load_valid(a_lv)
  );

  // DUT B: COUNT=2, WIDTH=12
  logic        rst_b = 1'b1;
  logic [63:0] b_din = '0;
  logic [9:0]  b_adr = '0;
  logic        b_wren = 1'b0, b_ssrst = 1'b0, b_cap = 1'b0, b_apply = 1'b0;
  logic [23:0] b_sin = '0;
  logic [63:0] b_dout;
  logic        b_busy, b_lv;
  logic [23:0] b_so;

  ss_regbank #(.BASE_INDEX(10'd32), .COUNT(2), .WIDTH(12), .DEFAULTS(DEFB)) dut_b (
    .clk(clk), .reset(rst_b), .ss_din(b_din), .ss_adr(b_adr), .ss_wren(b_wren),
    .ss_rst(b_ssrst), .ss_dout(b_dout), .ss_busy(b_busy), .capture(b_cap),
    .state_in(b_sin), .apply(b_apply), .state_out(b_so), .load_valid(b_lv)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0]    dout;
    logic           lv;
    logic           busy;
    logic [N*W-1:0] so;
  } exp_t;

  exp_t sb[$];

  // Reference model of DUT A
  logic [63:0] m_sh  [N];
  logic [63:0] m_out [N];
  logic [63:0] m_cap [N];
  bit          m_act;
  int          m_pos;

  function automatic logic [N*W-1:0] flat(input logic [63:0] a [N]);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = a[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_sh[i]  = DEF[i*W +: W];
      m_out[i] = DEF[i*W +: W];
      m_cap[i] = '0;
    end
    m_act = 0;
    m_pos = 0;
  endtask

  // One bus cycle on DUT A; the model's view of the following cycle is queued.
  task automatic drive(input bit wren, input int adr, input logic [63:0] din, input bit rs,
                       input bit cp, input bit ap, input logic [N*W-1:0] sin);
    exp_t        e;
    logic [63:0] nsh [N];
    bit          hit;
    int          off;
    @(negedge clk);
    a_wren = wren; a_adr = 10'(adr); a_din = din; a_ssrst = rs;
    a_cap = cp; a_apply = ap; a_sin = sin;
    hit    = (adr >= 32) && (adr < 32 + N);
    off    = adr - 32;
    e.dout = (!wren && hit) ? m_cap[off] : 64'd0;
    e.lv   = 1'b0;
    nsh    = m_sh;
`ifdef SS_REGBANK_SHADOW_EN
    if (wren && hit && !m_act) nsh[off] = din;
    if (m_act) begin
      nsh[m_pos] = DEF[m_pos*W +: W];
      if (rs) m_pos = 0;
      else if (m_pos == N - 1) begin
        m_out = nsh; e.lv = 1'b1; m_act = 0;
      end else m_pos++;
    end else begin
      if (ap) begin m_out = m_sh; e.lv = 1'b1; end
      if (rs) begin m_act = 1; m_pos = 0; end
    end
    m_sh = nsh;
`else
    if (wren && hit && !m_act) begin m_out[off] = din; e.lv = 1'b1; end
    if (m_act) begin
      m_out[m_pos] = DEF[m_pos*W +: W];
      e.lv = 1'b1;
      if (rs) m_pos = 0;
      else if (m_pos == N - 1) m_act = 0;
      else m_pos++;
    end else if (rs) begin
      m_act = 1; m_pos = 0;
    end
`endif
    if (cp) for (int i = 0; i < N; i++) m_cap[i] = sin[i*W +: W];
    e.busy = m_act;
    e.so   = flat(m_out);
    sb.push_back(e);
  endtask

  task automatic idle();
    drive(0, 0, 64'd0, 0, 0, 0, '0);
  endtask

  // Monitor: compare each queued expectation one step after the clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_dout", 256'(a_dout), 256'(e.dout));
        chk("sb_load_valid", 256'(a_lv), 256'(e.lv));
        chk("sb_busy", 256'(a_busy), 256'(e.busy));
        chk("sb_state_out", 256'(a_so), 256'(e.so));
      end
    end
  end

  initial begin
    logic [N*W-1:0] sin;
    logic [N*W-1:0] so_before;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state_out", a_so, DEF);
    chk("reset_dout", 256'(a_dout), 256'd0);
    chk("reset_busy", 256'(a_busy), 256'd0);
    chk("reset_lv", 256'(a_lv), 256'd0);
    chk("reset_b_state_out", 256'(b_so), 256'(DEFB));
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Write index 34 then apply
`ifdef SS_REGBANK_SHADOW_EN
    drive(1, 34, 64'hDEAD_BEEF, 0, 0, 0, '0);
    @(posedge clk); #2;
    chk("write_no_direct_update", a_so, DEF);
    drive(0, 0, 64'd0, 0, 0, 1, '0);
    @(posedge clk); #2;
    chk("apply_lv", 256'(a_lv), 256'd1);
    chk("apply_reg2", 256'(a_so[2*W +: W]), 256'h0DEAD_BEEF);
    chk("apply_reg0", 256'(a_so[0 +: W]), 256'h1111);
    so_before = a_so;
    drive(1, 34, 64'h1234, 0, 0, 1, '0);
    @(posedge clk); #2;
    chk("write_apply_same_cycle", a_so, so_before);
`else
    drive(1, 35, 64'hDEAD_BEEF, 0, 0, 0, '0);
    @(posedge clk); #2;
    chk("direct_lv", 256'(a_lv), 256'd1);
    chk("direct_reg3", 256'(a_so[3*W +: W]), 256'h0DEAD_BEEF);
    so_before = a_so;
    drive(0, 0, 64'd0, 0, 0, 1, '0);
    @(posedge clk); #2;
    chk("apply_ignored_lv", 256'(a_lv), 256'd0);
    chk("apply_ignored_so", a_so, so_before);
`endif

    // Capture then read
    sin = '0;
    sin[1*W +: W] = 64'hCAFE;
    drive(0, 0, 64'd0, 0, 1, 0, sin);
    drive(0, 33, 64'd0, 0, 0, 0, '0);
    @(posedge clk); #2;
    chk("read_capture", 256'(a_dout), 256'hCAFE);
    drive(0, 36, 64'd0, 0, 0, 0, '0);
    @(posedge clk); #2;
    chk("read_above", 256'(a_dout), 256'd0);
    drive(0, 31, 64'd0, 0, 0, 0, '0);
    @(posedge clk); #2;
    chk("read_below", 256'(a_dout), 256'd0);

    // Default walk
    drive(1, 33, 64'h77, 0, 0, 0, '0);
    drive(0, 0, 64'd0, 1, 0, 0, '0);
    @(posedge clk); #2;
    chk("walk_busy_1", 256'(a_busy), 256'd1);
    drive(1, 32, 64'h55, 0, 0, 1, '0);
    @(posedge clk); #2;
    chk("walk_busy_2", 256'(a_busy), 256'd1);
`ifdef SS_REGBANK_SHADOW_EN
    chk("walk_no_early_lv", 256'(a_lv), 256'd0);
`endif
    for (int i = 3; i <= 4; i++) begin
      idle();
      @(posedge clk); #2;
      chk($sformatf("walk_busy_%0d", i), 256'(a_busy), 256'd1);
    end
    idle();
    @(posedge clk); #2;
    chk("walk_end_busy", 256'(a_busy), 256'd0);
    chk("walk_end_lv", 256'(a_lv), 256'd1);
    chk("walk_end_defaults", a_so, DEF);
    idle();
    @(posedge clk); #2;
    chk("walk_single_pulse", 256'(a_lv), 256'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++) sin[i*W +: W] = {$urandom, $urandom};
      drive($urandom_range(0, 99) < 35, int'($urandom_range(28, 40)), {$urandom, $urandom},
            $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0, sin);
    end
    repeat (N + 2) idle();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #3;
    chk("scoreboard_drained", 256'(sb.size()), 256'd0);

    // DUT B: 12-bit registers
    @(negedge clk);
    b_wren = 1'b1; b_adr = 10'd32; b_din = 64'hFFFF;
    @(negedge clk);
    b_wren = 1'b0;
`ifdef SS_REGBANK_SHADOW_EN
    b_apply = 1'b1;
    @(negedge clk);
    b_apply = 1'b0;
`endif
    chk("b_write_truncated", 256'(b_so[11:0]), 256'hFFF);
    b_cap = 1'b1; b_sin = {12'h000, 12'hABC};
    @(negedge clk);
    b_cap = 1'b0; b_adr = 10'd32;
    @(posedge clk); #1;
    chk("b_read_zero_ext", 256'(b_dout), 256'hABC);
    @(negedge clk);
    b_adr = 10'd0; b_ssrst = 1'b1;
    @(negedge clk);
    b_ssrst = 1'b0;
    chk("b_walk_busy", 256'(b_busy), 256'd1);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk); #1;
    chk("b_reset_busy", 256'(b_busy), 256'd0);
    chk("b_reset_lv", 256'(b_lv), 256'd0);
    chk("b_reset_so", 256'(b_so), 256'(DEFB));
    @(negedge clk);
    rst_b = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
